// File: rtl/imem_responder_if.sv
// Fetch and program-load bus between the fetch/loader side (master) and the instruction memory (slave).
interface imem_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            oob;
    logic            load_start;
    logic [ADDR_W:0] load_len;
    logic [7:0]      load_data;
    logic            load_valid;
    logic            load_ready;
    logic            busy;
    logic            load_done;

    modport master (
        output pc, load_start, load_len, load_data, load_valid,
        input  instr, oob, load_ready, busy, load_done
    );

    modport slave (
        input  pc, load_start, load_len, load_data, load_valid,
        output instr, oob, load_ready, busy, load_done
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: registered word fetch plus a byte-serial
// little-endian program-load port that fills the memory from address 0.
module imem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    imem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    logic [31:0]         r_instr;
    logic                r_oob;
    logic                r_busy;
    logic                r_load_ready;
    logic                r_load_done;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [1:0]          r_byte_idx;
    logic [LEN_W-1:0]    r_words_left;
    logic [31:0]         r_asm;
    logic [31:0]         r_mem [DEPTH];

    logic                w_oob;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [LEN_W-1:0]    w_len_eff;
    logic                w_accept;
    logic                w_word_done;
    logic [31:0]         w_asm_next;

    // High PC bits are checked, never truncated, so out-of-range fetches cannot alias.
    assign w_oob       = |bus.pc[31:ADDR_W];
    assign w_rd_addr   = bus.pc[ADDR_W-1:0];
    assign w_len_eff   = (bus.load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.load_len;
    assign w_accept    = r_load_ready & bus.load_valid;
    assign w_word_done = w_accept & (r_byte_idx == 2'd3);

    // Insert the incoming byte into its little-endian lane of the assembly word.
    always_comb begin
        w_asm_next = r_asm;
        case (r_byte_idx)
            2'd0:    w_asm_next = {r_asm[31:8], bus.load_data};
            2'd1:    w_asm_next = {r_asm[31:16], bus.load_data, r_asm[7:0]};
            2'd2:    w_asm_next = {r_asm[31:24], bus.load_data, r_asm[15:0]};
            default: w_asm_next = {bus.load_data, r_asm[23:0]};
        endcase
    end

    // Memory write port; contents survive reset, and a write is suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (w_word_done && !reset) begin
            r_mem[r_wr_addr] <= w_asm_next;
        end
    end

    // Control FSM with registered fetch and load-handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_instr      <= NOP;
            r_oob        <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b0;
            r_load_done  <= 1'b0;
            r_wr_addr    <= '0;
            r_byte_idx   <= '0;
            r_words_left <= '0;
            r_asm        <= '0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_oob) begin
                        r_instr <= NOP;
                        r_oob   <= 1'b1;
                    end else begin
                        r_instr <= r_mem[w_rd_addr];
                        r_oob   <= 1'b0;
                    end
                    if (bus.load_start) begin
                        if (w_len_eff == '0) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= S_LOAD;
                            r_words_left <= w_len_eff;
                            r_wr_addr    <= '0;
                            r_byte_idx   <= '0;
                            r_busy       <= 1'b1;
                            r_load_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_instr <= NOP;
                    r_oob   <= 1'b0;
                    if (w_accept) begin
                        r_asm <= w_asm_next;
                        if (r_byte_idx == 2'd3) begin
                            r_byte_idx   <= '0;
                            r_wr_addr    <= r_wr_addr + ADDR_W'(1);
                            r_words_left <= r_words_left - LEN_W'(1);
                            if (r_words_left == LEN_W'(1)) begin
                                r_state      <= S_IDLE;
                                r_busy       <= 1'b0;
                                r_load_ready <= 1'b0;
                                r_load_done  <= 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr      = r_instr;
    assign bus.oob        = r_oob;
    assign bus.busy       = r_busy;
    assign bus.load_ready = r_load_ready;
    assign bus.load_done  = r_load_done;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized
// loads/fetches checked against a word-level memory model.
module tb_imem_responder;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic clk;
    logic reset;

    imem_responder_if #(.ADDR_W(ADDR_W)) bus_if ();

    imem_responder #(.ADDR_W(ADDR_W), .NOP(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: whole words as the loader should have written them.
    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];
    logic [7:0]  byte_q [$];

    // Observations recorded by the load driver.
    int   done_cnt;
    int   acc_cnt;
    logic start_busy;
    logic last_done;
    logic last_busy;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_if.load_done === 1'b1) done_cnt++;
    endtask

    // Apply the loader rules to the model; returns how many bytes should be accepted.
    function automatic int model_apply(input int len);
        int len_eff;
        int n_acc;
        len_eff = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        n_acc   = (byte_q.size() < 4 * len_eff) ? byte_q.size() : 4 * len_eff;
        for (int w = 0; w < n_acc / 4; w++) begin
            model_mem[w]   = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
            model_known[w] = 1'b1;
        end
        return n_acc;
    endfunction

    // Start a load and stream byte_q with random gaps, recording what the DUT did.
    task automatic drive_load(input int len, input int gap_max);
        logic was_ready;
        done_cnt   = 0;
        acc_cnt    = 0;
        last_done  = 1'b0;
        last_busy  = 1'b1;
        bus_if.load_start = 1'b1;
        bus_if.load_len   = (ADDR_W + 1)'(len);
        tick();
        bus_if.load_start = 1'b0;
        start_busy = bus_if.busy;
        for (int i = 0; i < byte_q.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
            bus_if.load_valid = 1'b1;
            bus_if.load_data  = byte_q[i];
            was_ready = bus_if.load_ready;
            tick();
            bus_if.load_valid = 1'b0;
            if (was_ready === 1'b1) begin
                acc_cnt++;
                last_done = bus_if.load_done;
                last_busy = bus_if.busy;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.pc = 32'd0;
        tick();
        tick();
        n_total++; if (bus_if.instr !== NOP) $display("FAIL reset_instr: got %h expected %h", bus_if.instr, NOP); else n_pass++;
        n_total++; if (bus_if.oob !== 1'b0) $display("FAIL reset_oob: got %b expected 0", bus_if.oob); else n_pass++;
        n_total++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_if.busy); else n_pass++;
        n_total++; if (bus_if.load_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus_if.load_ready); else n_pass++;
        n_total++; if (bus_if.load_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_if.load_done); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_load_two();
        int exp_acc;
        byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_acc = model_apply(2);
        drive_load(2, 3);
        n_total++; if (start_busy !== 1'b1) $display("FAIL two_start_busy: got %b expected 1", start_busy); else n_pass++;
        n_total++; if (acc_cnt !== exp_acc) $display("FAIL two_accepted: got %0d expected %0d", acc_cnt, exp_acc); else n_pass++;
        n_total++; if (last_done !== 1'b1 || last_busy !== 1'b0) $display("FAIL two_final_edge: got done=%b busy=%b expected done=1 busy=0", last_done, last_busy); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL two_done_pulses: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (bus_if.busy !== 1'b0) $display("FAIL two_busy_after: got %b expected 0", bus_if.busy); else n_pass++;
        bus_if.pc = 32'd1;
        tick();
        n_total++; if (bus_if.instr !== 32'hDEAD_BEEF) $display("FAIL two_fetch1: got %h expected deadbeef", bus_if.instr); else n_pass++;
        bus_if.pc = 32'd0;
        tick();
        n_total++; if (bus_if.instr !== 32'h1234_5678 || bus_if.oob !== 1'b0) $display("FAIL two_fetch0: got %h oob=%b expected 12345678 oob=0", bus_if.instr, bus_if.oob); else n_pass++;
    endtask

    task automatic test_oob();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0000_0100;
        pcs[1] = 32'h0000_0101;
        pcs[2] = 32'h8000_0001;
        for (int i = 0; i < 3; i++) begin
            bus_if.pc = pcs[i];
            tick();
            n_total++; if (bus_if.instr !== NOP || bus_if.oob !== 1'b1) $display("FAIL oob_pc_%h: got %h oob=%b expected %h oob=1", pcs[i], bus_if.instr, bus_if.oob, NOP); else n_pass++;
        end
        bus_if.pc = 32'd1;
        tick();
        n_total++; if (bus_if.instr !== model_mem[1] || bus_if.oob !== 1'b0) $display("FAIL oob_recover: got %h oob=%b expected %h oob=0", bus_if.instr, bus_if.oob, model_mem[1]); else n_pass++;
    endtask

    task automatic test_zero_len();
        byte_q = {};
        drive_load(0, 0);
        n_total++; if (start_busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", start_busy); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (bus_if.load_ready !== 1'b0 || bus_if.load_done !== 1'b0) $display("FAIL zero_after: got ready=%b done=%b expected 0 0", bus_if.load_ready, bus_if.load_done); else n_pass++;
    endtask

    task automatic test_clamp();
        int exp_acc;
        int a;
        byte_q = {};
        for (int i = 0; i < 4 * int'(DEPTH) + 8; i++) byte_q.push_back(8'($urandom));
        exp_acc = model_apply(300);
        drive_load(300, 0);
        n_total++; if (acc_cnt !== exp_acc) $display("FAIL clamp_accepted: got %0d expected %0d", acc_cnt, exp_acc); else n_pass++;
        n_total++; if (done_cnt !== 1 || bus_if.busy !== 1'b0) $display("FAIL clamp_done: got pulses=%0d busy=%b expected 1 0", done_cnt, bus_if.busy); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 255 : ((i == 1) ? 0 : int'($urandom_range(DEPTH - 1, 0)));
            bus_if.pc = 32'(a);
            tick();
            n_total++; if (bus_if.instr !== model_mem[a]) $display("FAIL clamp_fetch_%0d: got %h expected %h", a, bus_if.instr, model_mem[a]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] old1;
        logic [31:0] new0;
        old1 = model_mem[1];
        byte_q = {};
        for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
        void'(model_apply(2));
        drive_load(2, 1);
        reset = 1'b1;
        tick();
        n_total++; if (bus_if.busy !== 1'b0 || bus_if.load_ready !== 1'b0 || bus_if.instr !== NOP) $display("FAIL midreset_state: got busy=%b ready=%b instr=%h expected 0 0 %h", bus_if.busy, bus_if.load_ready, bus_if.instr, NOP); else n_pass++;
        reset = 1'b0;
        tick();
        n_total++; if (done_cnt !== 0) $display("FAIL midreset_no_done: got %0d expected 0", done_cnt); else n_pass++;
        bus_if.pc = 32'd0;
        tick();
        n_total++; if (bus_if.instr !== model_mem[0]) $display("FAIL midreset_word0: got %h expected %h", bus_if.instr, model_mem[0]); else n_pass++;
        bus_if.pc = 32'd1;
        tick();
        n_total++; if (bus_if.instr !== old1) $display("FAIL midreset_word1: got %h expected %h", bus_if.instr, old1); else n_pass++;
        byte_q = {};
        for (int i = 0; i < 4; i++) byte_q.push_back(8'($urandom));
        void'(model_apply(1));
        new0 = model_mem[0];
        drive_load(1, 2);
        n_total++; if (acc_cnt !== 4 || done_cnt !== 1) $display("FAIL midreset_reload: got acc=%0d pulses=%0d expected 4 1", acc_cnt, done_cnt); else n_pass++;
        bus_if.pc = 32'd0;
        tick();
        n_total++; if (bus_if.instr !== new0) $display("FAIL midreset_new0: got %h expected %h", bus_if.instr, new0); else n_pass++;
        bus_if.pc = 32'd1;
        tick();
        n_total++; if (bus_if.instr !== old1) $display("FAIL midreset_keep1: got %h expected %h", bus_if.instr, old1); else n_pass++;
    endtask

    task automatic test_load_start_ignored();
        byte_q = {};
        for (int i = 0; i < 4; i++) byte_q.push_back(8'($urandom));
        void'(model_apply(1));
        done_cnt = 0;
        bus_if.load_start = 1'b1;
        bus_if.load_len   = 9'd1;
        tick();
        bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = byte_q[0];
        tick();
        bus_if.load_valid = 1'b0;
        bus_if.load_start = 1'b1;
        bus_if.load_len   = 9'd5;
        bus_if.pc         = 32'd300;
        tick();
        bus_if.load_start = 1'b0;
        n_total++; if (bus_if.instr !== NOP || bus_if.oob !== 1'b0 || bus_if.busy !== 1'b1) $display("FAIL ign_during_load: got instr=%h oob=%b busy=%b expected %h 0 1", bus_if.instr, bus_if.oob, bus_if.busy, NOP); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            bus_if.pc         = 32'(i + 1);
            bus_if.load_valid = 1'b1;
            bus_if.load_data  = byte_q[i];
            tick();
            bus_if.load_valid = 1'b0;
            n_total++; if (bus_if.instr !== NOP) $display("FAIL ign_fetch_nop_%0d: got %h expected %h", i, bus_if.instr, NOP); else n_pass++;
        end
        n_total++; if (bus_if.load_done !== 1'b1 || bus_if.busy !== 1'b0) $display("FAIL ign_complete: got done=%b busy=%b expected 1 0", bus_if.load_done, bus_if.busy); else n_pass++;
        bus_if.pc = 32'd0;
        tick();
        tick();
        n_total++; if (bus_if.busy !== 1'b0 || done_cnt !== 1) $display("FAIL ign_no_restart: got busy=%b pulses=%0d expected 0 1", bus_if.busy, done_cnt); else n_pass++;
        n_total++; if (bus_if.instr !== model_mem[0]) $display("FAIL ign_word0: got %h expected %h", bus_if.instr, model_mem[0]); else n_pass++;
    endtask

    task automatic test_random();
        int len;
        int exp_acc;
        logic [31:0] p;
        logic [31:0] exp_instr;
        logic exp_oob;
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(6, 1));
            byte_q = {};
            for (int i = 0; i < 4 * len + int'($urandom_range(3, 0)); i++) byte_q.push_back(8'($urandom));
            exp_acc = model_apply(len);
            drive_load(len, 2);
            n_total++; if (acc_cnt !== exp_acc || done_cnt !== 1) $display("FAIL rand_load_%0d: got acc=%0d pulses=%0d expected %0d 1", r, acc_cnt, done_cnt, exp_acc); else n_pass++;
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(3, 0) == 0) p = $urandom | 32'h0000_0100;
                else p = 32'($urandom_range(DEPTH - 1, 0));
                exp_oob   = (p >= DEPTH);
                exp_instr = exp_oob ? NOP : model_mem[p[ADDR_W-1:0]];
                bus_if.pc = p;
                tick();
                if (exp_oob || model_known[p[ADDR_W-1:0]]) begin
                    n_total++; if (bus_if.instr !== exp_instr || bus_if.oob !== exp_oob) $display("FAIL rand_fetch_%h: got %h oob=%b expected %h oob=%b", p, bus_if.instr, bus_if.oob, exp_instr, exp_oob); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        bus_if.pc         = '0;
        bus_if.load_start = 1'b0;
        bus_if.load_len   = '0;
        bus_if.load_data  = '0;
        bus_if.load_valid = 1'b0;
        done_cnt          = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        test_reset();
        test_load_two();
        test_oob();
        test_zero_len();
        test_clamp();
        test_reset_mid_load();
        test_load_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
